if_id_stage_buffer: RTL and testbench

//   Pipeline boundary between instruction fetch and decode.
//   - Captures {pc, pc+4, instr} beats from fetch and holds them in a small FIFO.
//   - Presents beats to decode over a valid/ready handshake.
//   - Backpressures fetch (PC hold) when decode stalls.
//   - Discards all wrong-path beats on a taken branch/jump flush.

---
 rtl/mips_pkg.sv | 18 +
 rtl/if_id_entry_ram.sv | 26 ++
 rtl/if_id_stage_buffer.sv | 82 ++++++++
 tb/tb_if_id_stage_buffer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS constants, opcodes and the IF/ID entry layout.
package mips_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            cti;
    } if_id_entry_t;
    function automatic logic is_cti(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction
endpackage

// File: rtl/if_id_entry_ram.sv
// if_id_entry_ram: DEPTH x W register array, synchronous write, asynchronous read.
module if_id_entry_ram #(
    parameter int W     = 97,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_id_stage_buffer.sv
// if_id_stage_buffer: IF->ID FIFO with valid/ready handshake and flush.
// Define IFID_PREDECODE_EN to store a per-entry branch/jump flag (out_is_cti).
module if_id_stage_buffer
    import mips_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 2,
    parameter logic [DATA_W-1:0] NOP_INSTR = NOP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_pc_plus4,
    output logic [DATA_W-1:0] out_instr,
    output logic              out_is_cti
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef IFID_PREDECODE_EN
    localparam int EW = 3 * DATA_W + 1;
`else
    localparam int EW = 3 * DATA_W;
`endif

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;
    logic [EW-1:0]     wdata, rdata;
    logic [DATA_W-1:0] head_instr;

    assign in_ready  = count_q != CW'(DEPTH);
    assign out_valid = count_q != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // pc+4 is computed once at capture so decode never sees an adder in its path
`ifdef IFID_PREDECODE_EN
    assign wdata      = {in_pc, in_pc + DATA_W'(4), in_instr, is_cti(in_instr[31:26])};
    assign {out_pc, out_pc_plus4, head_instr} = rdata[EW-1:1];
    assign out_is_cti = out_valid & rdata[0];
`else
    assign wdata      = {in_pc, in_pc + DATA_W'(4), in_instr};
    assign {out_pc, out_pc_plus4, head_instr} = rdata;
    assign out_is_cti = 1'b0;
`endif
    assign out_instr  = out_valid ? head_instr : NOP_INSTR;

    if_id_entry_ram #(.W(EW), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );
endmodule

// File: tb/tb_if_id_stage_buffer.sv
// tb_if_id_stage_buffer: table-driven checks plus hand-written reset sequence.
module tb_if_id_stage_buffer;
`ifdef IFID_PREDECODE_EN
    localparam logic PD = 1'b1;
`else
    localparam logic PD = 1'b0;
`endif
    localparam logic [31:0] ADD  = 32'h0000_0020;
    localparam logic [31:0] BEQ  = 32'h1000_0003;
    localparam logic [31:0] J    = 32'h0800_0010;
    localparam logic [31:0] JAL  = 32'h0C00_0040;
    localparam logic [31:0] BNE  = 32'h1400_0001;
    localparam logic [31:0] ADDI = 32'h2000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0, out_is_cti;
    logic [31:0] in_pc = '0, in_instr = '0, out_pc, out_pc_plus4, out_instr;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    if_id_stage_buffer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .out_instr(out_instr), .out_is_cti(out_is_cti)
    );

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fl;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic [31:0] epc;
        logic [31:0] epc4;
        logic [31:0] einstr;
        logic        ecti;
    } vec_t;

    vec_t v[19];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // iv pc instr fl ordy | ov ir pc pc4 instr cti  (outputs after the edge)
        v[0]  = '{1, 32'h0,   ADD,  0, 1,  1, 1, 32'h0,   32'h4,   ADD,  0};
        v[1]  = '{1, 32'h4,   BEQ,  0, 1,  1, 1, 32'h4,   32'h8,   BEQ,  1};
        v[2]  = '{1, 32'h8,   J,    0, 1,  1, 1, 32'h8,   32'hC,   J,    1};
        v[3]  = '{0, 32'h0,   ADD,  0, 1,  0, 1, 32'h0,   32'h0,   32'h0, 0};
        v[4]  = '{1, 32'h100, ADD,  0, 0,  1, 1, 32'h100, 32'h104, ADD,  0};
        v[5]  = '{1, 32'h104, JAL,  0, 0,  1, 0, 32'h100, 32'h104, ADD,  0};
        v[6]  = '{1, 32'h108, BNE,  0, 0,  1, 0, 32'h100, 32'h104, ADD,  0};
        v[7]  = '{1, 32'h108, BNE,  0, 1,  1, 1, 32'h104, 32'h108, JAL,  1};
        v[8]  = '{1, 32'h108, BNE,  0, 1,  1, 1, 32'h108, 32'h10C, BNE,  1};
        v[9]  = '{0, 32'h0,   ADD,  0, 1,  0, 1, 32'h0,   32'h0,   32'h0, 0};
        v[10] = '{1, 32'h200, 32'h21, 0, 0, 1, 1, 32'h200, 32'h204, 32'h21, 0};
        v[11] = '{1, 32'h204, ADDI, 0, 0,  1, 0, 32'h200, 32'h204, 32'h21, 0};
        v[12] = '{1, 32'h10,  BEQ,  1, 1,  0, 1, 32'h0,   32'h0,   32'h0, 0};
        v[13] = '{1, 32'h10,  BEQ,  1, 0,  0, 1, 32'h0,   32'h0,   32'h0, 0};
        v[14] = '{0, 32'h10,  BEQ,  0, 0,  0, 1, 32'h0,   32'h0,   32'h0, 0};
        v[15] = '{1, 32'hFFFF_FFFC, ADD, 0, 1, 1, 1, 32'hFFFF_FFFC, 32'h0, ADD, 0};
        v[16] = '{0, 32'h0,   ADD,  0, 1,  0, 1, 32'h0,   32'h0,   32'h0, 0};
        v[17] = '{1, 32'h300, BEQ,  0, 0,  1, 1, 32'h300, 32'h304, BEQ,  1};
        v[18] = '{1, 32'h304, ADD,  0, 0,  1, 0, 32'h300, 32'h304, BEQ,  1};

        #12;
        chk("rst_out_valid", -1, {31'b0, out_valid}, 32'h0);
        chk("rst_in_ready", -1, {31'b0, in_ready}, 32'h1);
        chk("rst_out_instr", -1, out_instr, 32'h0);
        chk("rst_out_pc", -1, out_pc, 32'h0);
        chk("rst_out_pc_plus4", -1, out_pc_plus4, 32'h0);
        chk("rst_out_is_cti", -1, {31'b0, out_is_cti}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            in_valid  = v[i].iv;
            in_pc     = v[i].pc;
            in_instr  = v[i].instr;
            flush     = v[i].fl;
            out_ready = v[i].ordy;
            @(posedge clk);
            #1;
            chk("out_valid", i, {31'b0, out_valid}, {31'b0, v[i].ov});
            chk("in_ready", i, {31'b0, in_ready}, {31'b0, v[i].ir});
            chk("out_instr", i, out_instr, v[i].einstr);
            chk("out_is_cti", i, {31'b0, out_is_cti}, {31'b0, v[i].ov & v[i].ecti & PD});
            if (v[i].ov) begin
                chk("out_pc", i, out_pc, v[i].epc);
                chk("out_pc_plus4", i, out_pc_plus4, v[i].epc4);
            end
        end

        // asynchronous reset with two entries held
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 19, {31'b0, out_valid}, 32'h0);
        chk("mid_rst_in_ready", 19, {31'b0, in_ready}, 32'h1);
        chk("mid_rst_out_instr", 19, out_instr, 32'h0);
        chk("mid_rst_out_pc", 19, out_pc, 32'h0);
        chk("mid_rst_out_is_cti", 19, {31'b0, out_is_cti}, 32'h0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 20, {31'b0, out_valid}, 32'h0);
        chk("post_rst_in_ready", 20, {31'b0, in_ready}, 32'h1);
        in_valid = 1'b1;
        in_pc    = 32'h400;
        in_instr = BNE;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_rst_push_pc", 21, out_pc, 32'h400);
        chk("post_rst_push_instr", 21, out_instr, BNE);
        chk("post_rst_push_cti", 21, {31'b0, out_is_cti}, {31'b0, PD});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
